// File: rtl/muxn_pipe_if.sv
// Handshake/bus bundle for muxn_pipe: producer-side inputs plus registered consumer-side outputs.
interface muxn_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_bus, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport slave (
    input  in_bus, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/muxn_pipe.sv
// N-input registered select stage with valid/ready, one-entry skid buffer and flush.
// Optional sticky out-of-range select flag enabled by MUXN_PIPE_SEL_CHK_EN.
module muxn_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic         clk,
  input  logic         rst,
  muxn_pipe_if.slave   bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load_or_in;
  logic              w_load_or_sk;
  logic              w_load_sk;
  logic              w_accept;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_sel_data;

  logic [WIDTH-1:0]  r_or_data;
  logic [SEL_W-1:0]  r_or_sel;
  logic [WIDTH-1:0]  r_sk_data;
  logic [SEL_W-1:0]  r_sk_sel;
  logic              r_out_valid;
  logic              r_in_ready;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_xfer   = r_out_valid && bus.out_ready;

  // Lane mux; out-of-range selects fall through to zero
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) w_sel_data = bus.in_bus[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Occupancy FSM; flush wins over any accept/transfer in the same cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_load_or_in = 1'b0;
    w_load_or_sk = 1'b0;
    w_load_sk    = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_load_or_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            w_load_or_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_sk   = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            w_state_nxt  = ST_ONE;
            w_load_or_sk = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_data   <= '0;
      r_or_sel    <= '0;
      r_sk_data   <= '0;
      r_sk_sel    <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
      if (w_load_or_in) begin
        r_or_data <= w_sel_data;
        r_or_sel  <= bus.sel;
      end else if (w_load_or_sk) begin
        r_or_data <= r_sk_data;
        r_or_sel  <= r_sk_sel;
      end
      if (w_load_sk) begin
        r_sk_data <= w_sel_data;
        r_sk_sel  <= bus.sel;
      end
    end
  end

  assign bus.out_data  = r_or_data;
  assign bus.out_sel   = r_or_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;

`ifdef MUXN_PIPE_SEL_CHK_EN
  logic r_sel_err;
  logic w_sel_oor;

  // Extra bit keeps the compare correct when NUM_IN == 2**SEL_W
  assign w_sel_oor = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clk) begin
    if (rst)                                       r_sel_err <= 1'b0;
    else if (w_accept && !bus.flush && w_sel_oor)  r_sel_err <= 1'b1;
  end

  assign bus.sel_err = r_sel_err;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised N-input, registered operand-select stage for the 5-stage pipeline. It replaces fixed-width, fixed-fan-in combinational selects (for example operand forwarding and writeback source selection) where the selected value must cross a stage boundary. It selects one of `NUM_IN` lanes, registers the result with a valid/ready handshake, and absorbs one cycle of downstream back-pressure in a one-entry skid buffer. It also supports pipeline flush.

## Interface
Parameters:
- `WIDTH`, 32, data bits per lane
- `NUM_IN`, 8, number of input lanes (2..16)
- `SEL_W`, 3, select width; must satisfy 2^`SEL_W` >= `NUM_IN`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `in_bus`  in  `NUM_IN*WIDTH`  lane i = `in_bus[i*WIDTH +: WIDTH]`
- `sel`  in  `SEL_W`  lane index
- `in_valid`  in  1  `in_bus`/`sel` valid this cycle
- `in_ready`  out  1  stage can accept this cycle
- `flush`  in  1  discard all held data
- `out_data`  out  `WIDTH`  registered selected lane
- `out_sel`  out  `SEL_W`  registered copy of `sel` for the item in `out_data`
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts this cycle
- `sel_err`  out  1  sticky out-of-range select flag (see Configuration)

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- Select: the selected value is lane `sel` when `sel < NUM_IN`. When `sel >= NUM_IN`, the selected value is all zeros and the item is still transferred.
- Storage is an output register (OR) plus one skid entry (SK). State is EMPTY (OR invalid), ONE (OR valid, SK empty) or FULL (both valid).
  - EMPTY + accept: go to ONE; OR gets the item.
  - ONE + accept + transfer out: stay in ONE; OR gets the new item.
  - ONE + accept, no transfer out: go to FULL; SK gets the item.
  - ONE + transfer out, no accept: go to EMPTY.
  - FULL + transfer out: go to ONE; OR gets SK. No accept is possible in FULL.
- `in_ready` is registered. It is 1 in EMPTY and ONE, and 0 in FULL.
- Order is strictly preserved; the item in SK never overtakes the item in OR.
- `flush` has priority over accept and transfer in the same cycle. Next state is EMPTY, `out_valid`=0 and `in_ready`=1. An item presented with `flush` is dropped. `out_data` and `out_sel` keep their last values; they are don't-care while `out_valid`=0.
- Reset values: `out_data`=0, `out_sel`=0, `out_valid`=0, `in_ready`=1, `sel_err`=0, state EMPTY.
- While `rst`=1, `in_valid` and `flush` are ignored.
- Reset asserted in the middle of operation discards OR and SK contents at that edge.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 item per cycle while `out_ready`=1.
- `in_ready` falls the cycle after OR is stalled while SK is filled. It rises the cycle after SK drains.
- `out_valid`, `out_data` and `out_sel` are register outputs with no combinational path from inputs.
- `out_data` and `out_sel` hold stable while `out_valid && !out_ready`.

## Configuration
- `MUXN_PIPE_SEL_CHK_EN` defined:
  - Accepting an item with `sel >= NUM_IN` sets `sel_err` to 1 on the accept edge.
  - `sel_err` stays set until `rst`; `flush` does not clear it.
  - The transferred data is zero.
- `MUXN_PIPE_SEL_CHK_EN` undefined:
  - `sel_err` is tied to 0.
  - Out-of-range selects still produce zero data.
  - No check logic is synthesised.

## Test plan
- Streaming: `WIDTH`=32, `NUM_IN`=8, `out_ready`=1, lane i = 0x1000+i, `sel` stepping 0..7 on consecutive cycles. Expect `out_data` 0x1000..0x1007 one cycle later, back-to-back, with `in_ready` held at 1.
- Back-pressure: accept A (`sel`=2) then B (`sel`=5) with `out_ready`=0. Expect `in_ready`=0 after B is accepted and `out_data` held at lane 2. Raise `out_ready` for 2 cycles: expect A then B out, and `in_ready`=1 again.
- Flush: state FULL, assert `flush` together with `in_valid` and `out_ready`. Next cycle expect `out_valid`=0 and `in_ready`=1, with neither the in-flight item nor the flushed items ever appearing at the output.
- Out-of-range select: `NUM_IN`=6, `sel`=7 accepted. Expect `out_data`=0 and `out_sel`=7. With the macro defined, `sel_err`=1 and it persists through a later `flush`. Without the macro, `sel_err`=0.
- Reset mid-operation: state FULL, assert `rst` for 1 cycle with `in_valid`=1. Expect `out_valid`=0, `out_data`=0 and `in_ready`=1 after the edge, and the presented item not accepted.
